ex_hazard_ctrl: RTL

- Sequencing controller for the execute stage of the 5-stage RV32 pipeline.
- Generates forwarding selects for the EX operand muxes (i_mux1_sel / i_mux2_sel encoding).
- Runs load-use stalls, branch/jump redirect flushes and a multi-cycle MDU handshake with timeout.
- Maintains three performance counters; sits beside the pipeline registers, driving stall/flush enables of IF, ID, EX and the EX→MEM register.

---
 rtl/ex_hazard_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage hazard controller: forwarding, load-use stalls, redirect flushes, MDU wait
module ex_hazard_ctrl #(
    parameter int LOAD_USE_STALLS = 2,
    parameter int MDU_TIMEOUT     = 64,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             boj_e,
    input  logic             jalr_e,
    input  logic [4:0]       rd_m,
    input  logic             regsrc_m,
    input  logic [4:0]       rd_w,
    input  logic             regsrc_w,
    input  logic             mdu_req_e,
    input  logic             mdu_done,
    output logic [1:0]       mux1_sel,
    output logic [1:0]       mux2_sel,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mdu_go,
    output logic             mdu_err,
    output logic [CNT_W-1:0] cnt_load_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_mdu
);

    typedef enum logic [1:0] {S_RUN, S_LOAD_STALL, S_MDU_WAIT} state_t;

    state_t     state, state_nxt;
    logic [2:0] lcnt, lcnt_nxt;
    logic [9:0] timer, timer_nxt;

    logic redirect, load_use, mdu_timeout;
    logic inc_load, inc_flush, inc_mdu, err_set;
    logic sf, sd, se, fd, fe, fm, go;

    // MEM result is younger than WB, so it wins when both target the same register
    always_comb begin
        mux1_sel = 2'b00;
        if (regsrc_m && rd_m != 5'd0 && rd_m == rs1_e)
            mux1_sel = 2'b01;
        else if (regsrc_w && rd_w != 5'd0 && rd_w == rs1_e)
            mux1_sel = 2'b10;
    end

    always_comb begin
        mux2_sel = 2'b00;
        if (regsrc_m && rd_m != 5'd0 && rd_m == rs2_e)
            mux2_sel = 2'b01;
        else if (regsrc_w && rd_w != 5'd0 && rd_w == rs2_e)
            mux2_sel = 2'b10;
    end

    assign redirect    = boj_e | jalr_e;
    assign load_use    = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    assign mdu_timeout = (timer == 10'(MDU_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            lcnt  <= 3'd0;
            timer <= 10'd0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        timer_nxt = timer;
        case (state)
            S_RUN: begin
                if (redirect) begin
                    state_nxt = S_RUN;
                end else if (mdu_req_e) begin
                    state_nxt = S_MDU_WAIT;
                    timer_nxt = 10'd0;
                end else if (load_use && LOAD_USE_STALLS > 1) begin
                    state_nxt = S_LOAD_STALL;
                    lcnt_nxt  = 3'd1;
                end
            end
            S_LOAD_STALL: begin
                lcnt_nxt = lcnt + 3'd1;
                if (lcnt == 3'(LOAD_USE_STALLS - 1))
                    state_nxt = S_RUN;
            end
            S_MDU_WAIT: begin
                timer_nxt = timer + 10'd1;
                if (mdu_done || mdu_timeout)
                    state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        sf = 1'b0; sd = 1'b0; se = 1'b0;
        fd = 1'b0; fe = 1'b0; fm = 1'b0;
        go = 1'b0;
        inc_load = 1'b0; inc_flush = 1'b0; inc_mdu = 1'b0; err_set = 1'b0;
        case (state)
            S_RUN: begin
                if (redirect) begin
                    fd = 1'b1; fe = 1'b1;
                    inc_flush = 1'b1;
                end else if (mdu_req_e) begin
                    go = 1'b1;
                    sf = 1'b1; sd = 1'b1; se = 1'b1; fm = 1'b1;
                end else if (load_use) begin
                    sf = 1'b1; sd = 1'b1; fe = 1'b1;
                    inc_load = 1'b1;
                end
            end
            S_LOAD_STALL: begin
                sf = 1'b1; sd = 1'b1; fe = 1'b1;
                inc_load = 1'b1;
            end
            S_MDU_WAIT: begin
                inc_mdu = 1'b1;
                // The release cycle lets EX capture the MDU result, so nothing is held
                if (!(mdu_done || mdu_timeout)) begin
                    sf = 1'b1; sd = 1'b1; se = 1'b1; fm = 1'b1;
                end
                err_set = mdu_timeout && !mdu_done;
            end
            default: ;
        endcase
    end

    assign stall_f = sf & rst_n;
    assign stall_d = sd & rst_n;
    assign stall_e = se & rst_n;
    assign flush_d = fd & rst_n;
    assign flush_e = fe & rst_n;
    assign flush_m = fm & rst_n;
    assign mdu_go  = go & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_err        <= 1'b0;
            cnt_load_stall <= '0;
            cnt_flush      <= '0;
            cnt_mdu        <= '0;
        end else begin
            if (err_set)   mdu_err        <= 1'b1;
            if (inc_load)  cnt_load_stall <= cnt_load_stall + 1'b1;
            if (inc_flush) cnt_flush      <= cnt_flush + 1'b1;
            if (inc_mdu)   cnt_mdu        <= cnt_mdu + 1'b1;
        end
    end

endmodule
